// File: rtl/mul_tree_bf16_param.sv
// mul_tree_bf16_param: pipelined bf16 multiplier tree. Each beat carries its own product depth
// (mode), so lanes are reduced pairwise for mode levels and then passed through unchanged.
// Latency is fixed at LEVELS cycles and a single enable stalls the whole pipe under backpressure.
module mul_tree_bf16_param #(
   parameter int unsigned  N_IN   = 8,
   localparam int unsigned LEVELS = $clog2(N_IN),
   localparam int unsigned MW     = $clog2(LEVELS + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_vld,
   output logic                   in_rdy,
   input  logic [N_IN*16-1:0]     mul_ins,
   input  logic [MW-1:0]          mode,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [(N_IN/2)*16-1:0] outputs,
   output logic [N_IN/2-1:0]      out_lane_vld
);

   localparam int unsigned NL = N_IN / 2;

   // bf16 multiply, round to nearest even, flush-to-zero on underflow, no subnormal outputs
   function automatic logic [15:0] bf16mul(input logic [15:0] a, input logic [15:0] b);
      logic               sgn;
      logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [15:0]        prod;
      logic               norm;
      logic [6:0]         mant;
      logic               guard, sticky, rnd_up;
      logic [7:0]         mant_rnd;
      logic signed [10:0] exp_b;
      logic [15:0]        res;
      sgn      = a[15] ^ b[15];
      a_zero   = (a[14:7] == 8'h00);
      b_zero   = (b[14:7] == 8'h00);
      a_inf    = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
      b_inf    = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
      a_nan    = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
      b_nan    = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
      prod     = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
      norm     = prod[15];
      mant     = norm ? prod[14:8] : prod[13:7];
      guard    = norm ? prod[7] : prod[6];
      sticky   = norm ? (|prod[6:0]) : (|prod[5:0]);
      rnd_up   = guard & (sticky | mant[0]);
      mant_rnd = {1'b0, mant} + {7'h00, rnd_up};
      // A rounding carry leaves mant_rnd[6:0] at zero, so only the exponent needs the bump.
      exp_b    = $signed({3'b000, a[14:7]} + {3'b000, b[14:7]} + {10'h000, norm}
                         + {10'h000, mant_rnd[7]} - 11'd127);
      if (a_nan || b_nan) begin
         res = 16'h7FC0;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         res = 16'h7FC0;
      end else if (a_inf || b_inf) begin
         res = {sgn, 8'hFF, 7'h00};
      end else if (a_zero || b_zero) begin
         res = {sgn, 15'h0000};
      end else if (exp_b >= 11'sd255) begin
         res = {sgn, 8'hFF, 7'h00};
      end else if (exp_b <= 11'sd0) begin
         res = {sgn, 15'h0000};
      end else begin
         res = {sgn, exp_b[7:0], mant_rnd[6:0]};
      end
      return res;
   endfunction

   logic [LEVELS-1:0] r_vld;
   logic [MW-1:0]     r_mode [LEVELS];
   logic [NL*16-1:0]  r_data [LEVELS];
   logic [NL*16-1:0]  w_next [LEVELS];
   logic [MW-1:0]     w_mode_eff;
   logic [NL-1:0]     w_mask;
   logic              w_en;

   assign w_en    = !out_vld || out_rdy;
   assign in_rdy  = w_en;
   assign out_vld = r_vld[LEVELS-1];
   assign outputs = r_data[LEVELS-1];

   // Clamp mode into 1..LEVELS before it travels with the beat
   always_comb begin
      if (mode == '0) begin
         w_mode_eff = MW'(1);
      end else if (32'(mode) > LEVELS) begin
         w_mode_eff = MW'(LEVELS);
      end else begin
         w_mode_eff = mode;
      end
   end

   // Per-stage next data: reduce pairs while the level is within the beat's mode, else copy
   always_comb begin
      for (int s = 0; s < LEVELS; s++) begin
         w_next[s] = '0;
      end
      // Level 1 always multiplies because the effective mode is never below 1
      for (int j = 0; j < NL; j++) begin
         w_next[0][16*j +: 16] = bf16mul(mul_ins[32*j +: 16], mul_ins[32*j+16 +: 16]);
      end
      for (int s = 1; s < LEVELS; s++) begin
         if (s + 1 <= 32'(r_mode[s-1])) begin
            // From level 2 on only the lower half of the lanes can hold live products
            for (int j = 0; j < NL / 2; j++) begin
               if (j < (N_IN >> (s + 1))) begin
                  w_next[s][16*j +: 16] = bf16mul(r_data[s-1][32*j +: 16],
                                                  r_data[s-1][32*j+16 +: 16]);
               end
            end
         end else begin
            w_next[s] = r_data[s-1];
         end
      end
   end

   // Lane mask of the beat at the output stage
   always_comb begin
      for (int j = 0; j < NL; j++) begin
         w_mask[j] = (j < (N_IN >> r_mode[LEVELS-1]));
      end
   end

   assign out_lane_vld = r_vld[LEVELS-1] ? w_mask : '0;

   // Pipeline registers: all stages advance together on enable, bubbles enter when idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld <= '0;
         for (int s = 0; s < LEVELS; s++) begin
            r_mode[s] <= '0;
            r_data[s] <= '0;
         end
      end else if (w_en) begin
         r_vld[0]  <= in_vld;
         r_mode[0] <= w_mode_eff;
         r_data[0] <= w_next[0];
         for (int s = 1; s < LEVELS; s++) begin
            r_vld[s]  <= r_vld[s-1];
            r_mode[s] <= r_mode[s-1];
            r_data[s] <= w_next[s];
         end
      end
   end

endmodule

// File: tb/tb_mul_tree_bf16_param.sv
// Self-checking bench for mul_tree_bf16_param (N_IN = 8). Expected results come from a
// real-arithmetic bf16 model and a lane-list tree reduction.
module tb_mul_tree_bf16_param;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_vld = 1'b0;
   logic          in_rdy;
   logic [127:0]  mul_ins = '0;
   logic [1:0]    mode = 2'd1;
   logic          out_vld;
   logic          out_rdy = 1'b1;
   logic [63:0]   outputs;
   logic [3:0]    out_lane_vld;

   int n_checks = 0;
   int n_fail   = 0;

   mul_tree_bf16_param #(.N_IN(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_vld       (in_vld),
      .in_rdy       (in_rdy),
      .mul_ins      (mul_ins),
      .mode         (mode),
      .out_vld      (out_vld),
      .out_rdy      (out_rdy),
      .outputs      (outputs),
      .out_lane_vld (out_lane_vld)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic real pow2(input int n);
      real r;
      r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   // Exact product in real arithmetic, then rounded to an 8-bit significand (ties to even)
   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      logic s;
      bit   a_nan, b_nan, a_inf, b_inf, a_z, b_z;
      int   ea, eb, ma, mb, e, qi, be;
      real  x, q, fr;
      s     = a[15] ^ b[15];
      ea    = int'(a[14:7]);
      eb    = int'(b[14:7]);
      ma    = int'(a[6:0]);
      mb    = int'(b[6:0]);
      a_nan = (ea == 255) && (ma != 0);
      b_nan = (eb == 255) && (mb != 0);
      a_inf = (ea == 255) && (ma == 0);
      b_inf = (eb == 255) && (mb == 0);
      a_z   = (ea == 0);
      b_z   = (eb == 0);
      if (a_nan || b_nan) return 16'h7FC0;
      if ((a_inf && b_z) || (b_inf && a_z)) return 16'h7FC0;
      if (a_inf || b_inf) return {s, 8'hFF, 7'h00};
      if (a_z || b_z) return {s, 15'h0000};
      x = real'((128 + ma) * (128 + mb)) * pow2(ea + eb - 254 - 14);
      e = 0;
      while (x >= 2.0) begin x = x / 2.0; e++; end
      while (x < 1.0) begin x = x * 2.0; e--; end
      q  = x * 128.0;
      qi = $rtoi(q);
      fr = q - real'(qi);
      if (fr > 0.5 || (fr == 0.5 && (qi % 2) == 1)) qi++;
      if (qi == 256) begin qi = 128; e++; end
      be = e + 127;
      if (be >= 255) return {s, 8'hFF, 7'h00};
      if (be <= 0) return {s, 15'h0000};
      return {s, be[7:0], qi[6:0]};
   endfunction

   // Reduce the lane list pairwise for the clamped number of levels, pad with zero lanes
   function automatic void ref_tree(input logic [127:0] ins, input int md,
                                    output logic [63:0] o, output logic [3:0] m);
      logic [15:0] cur [8];
      int lv, n;
      lv = (md == 0) ? 1 : ((md > 3) ? 3 : md);
      for (int i = 0; i < 8; i++) cur[i] = ins[16*i +: 16];
      n = 8;
      repeat (lv) begin
         for (int j = 0; j < n / 2; j++) cur[j] = ref_mul(cur[2*j], cur[2*j+1]);
         n = n / 2;
      end
      o = '0;
      m = '0;
      for (int j = 0; j < n; j++) begin
         o[16*j +: 16] = cur[j];
         m[j] = 1'b1;
      end
   endfunction

   function automatic logic [15:0] rand_op();
      logic [31:0] r;
      logic [15:0] v;
      r = $urandom;
      v = {r[31], 8'(118 + int'(r[7:0] % 8'd19)), r[14:8]};
      if (r[19:16] == 4'd0) v[14:7] = 8'h00;
      else if (r[19:16] == 4'd1) v[14:7] = 8'hFF;
      else if (r[19:16] == 4'd2) v[14:0] = 15'h0000;
      return v;
   endfunction

   function automatic logic [127:0] rand_beat();
      logic [127:0] d;
      for (int i = 0; i < 8; i++) d[16*i +: 16] = rand_op();
      return d;
   endfunction

   // Drive one beat into an empty pipe and collect its result; lat counts cycles to out_vld
   task automatic run_beat(input logic [127:0] d, input logic [1:0] md,
                           output logic [63:0] o, output logic [3:0] m, output int lat);
      @(negedge clk);
      out_rdy = 1'b1;
      in_vld  = 1'b1;
      mul_ins = d;
      mode    = md;
      @(negedge clk);
      in_vld = 1'b0;
      lat = 1;
      while (out_vld !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      o = outputs;
      m = out_lane_vld;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_vld !== 1'b0 || outputs !== 64'h0 || out_lane_vld !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_state: out_vld=%b outputs=%h mask=%b, required 0/0/0",
                  out_vld, outputs, out_lane_vld);
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: in_rdy=%b out_vld=%b, required 1/0", in_rdy, out_vld);
      end
   endtask

   task automatic test_pairwise();
      logic [63:0] o;
      logic [3:0]  m;
      int          lat;
      run_beat({16'h3F00, 16'hC000, 16'h3F80, 16'h3F80, 16'h4000, 16'h3FC0, 16'h4040, 16'h4000},
               2'd1, o, m, lat);
      n_checks++;
      if (lat !== 3) begin
         n_fail++;
         $display("FAIL pair_latency: got %0d cycles, required 3", lat);
      end
      n_checks++;
      if (o !== 64'hBF80_3F80_4040_40C0) begin
         n_fail++;
         $display("FAIL pair_outputs: got %h, required BF803F80404040C0", o);
      end
      n_checks++;
      if (m !== 4'b1111) begin
         n_fail++;
         $display("FAIL pair_mask: got %b, required 1111", m);
      end
   endtask

   task automatic test_modes();
      logic [63:0] o;
      logic [3:0]  m;
      int          lat;
      logic [1:0]  mds  [3];
      logic [63:0] eo   [3];
      logic [3:0]  em   [3];
      mds = '{2'd3, 2'd2, 2'd0};
      eo  = '{64'h0000_0000_0000_4380, 64'h0000_0000_4180_4180, 64'h4080_4080_4080_4080};
      em  = '{4'b0001, 4'b0011, 4'b1111};
      for (int t = 0; t < 3; t++) begin
         run_beat({8{16'h4000}}, mds[t], o, m, lat);
         n_checks++;
         if (o !== eo[t] || m !== em[t] || lat !== 3) begin
            n_fail++;
            $display("FAIL mode%0d: outputs=%h mask=%b lat=%0d, required %h %b 3",
                     mds[t], o, m, lat, eo[t], em[t]);
         end
      end
   endtask

   task automatic test_special();
      logic [15:0]  a_op [12];
      logic [15:0]  b_op [12];
      logic [15:0]  ex   [12];
      logic [127:0] d;
      logic [63:0]  o;
      logic [3:0]   m;
      int           lat;
      a_op = '{16'h7F80, 16'h7F00, 16'h0080, 16'h8080, 16'h7FC1, 16'h3F81,
               16'h3F81, 16'h3F83, 16'h3FC1, 16'hFF80, 16'h7F80, 16'h7F80};
      b_op = '{16'h0000, 16'h7F00, 16'h0080, 16'h0080, 16'h3F80, 16'h3F81,
               16'h3FC0, 16'h3FC0, 16'h3FC1, 16'h3F80, 16'h0001, 16'hFF80};
      ex   = '{16'h7FC0, 16'h7F80, 16'h0000, 16'h8000, 16'h7FC0, 16'h3F82,
               16'h3FC2, 16'h3FC4, 16'h4012, 16'hFF80, 16'h7FC0, 16'hFF80};
      for (int bt = 0; bt < 3; bt++) begin
         for (int l = 0; l < 4; l++) begin
            d[32*l +: 16]    = a_op[4*bt+l];
            d[32*l+16 +: 16] = b_op[4*bt+l];
         end
         run_beat(d, 2'd1, o, m, lat);
         for (int l = 0; l < 4; l++) begin
            n_checks++;
            if (o[16*l +: 16] !== ex[4*bt+l]) begin
               n_fail++;
               $display("FAIL special %h*%h: got %h, required %h",
                        a_op[4*bt+l], b_op[4*bt+l], o[16*l +: 16], ex[4*bt+l]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] beats [16];
      logic [1:0]   mds   [16];
      logic [63:0]  exp_o [$];
      logic [3:0]   exp_m [$];
      logic [63:0]  eo, snap_o;
      logic [3:0]   em, snap_m;
      int           sent, got, cyc;
      for (int i = 0; i < 16; i++) begin
         beats[i] = rand_beat();
         mds[i]   = 2'(i % 4);
         ref_tree(beats[i], i % 4, eo, em);
         exp_o.push_back(eo);
         exp_m.push_back(em);
      end
      sent = 0; got = 0; cyc = 0; snap_o = '0; snap_m = '0;
      while (got < 16 && cyc < 200) begin
         @(negedge clk);
         out_rdy = !(cyc >= 8 && cyc <= 12);
         in_vld  = (sent < 16);
         if (sent < 16) begin
            mul_ins = beats[sent];
            mode    = mds[sent];
         end
         #1;
         if (cyc >= 8 && cyc <= 12) begin
            n_checks++;
            if (in_rdy !== 1'b0 || out_vld !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_hold_rdy cyc %0d: in_rdy=%b out_vld=%b, required 0/1",
                        cyc, in_rdy, out_vld);
            end
         end
         if (cyc == 8) begin
            snap_o = outputs;
            snap_m = out_lane_vld;
         end else if (cyc > 8 && cyc <= 12) begin
            n_checks++;
            if (outputs !== snap_o || out_lane_vld !== snap_m) begin
               n_fail++;
               $display("FAIL b2b_frozen cyc %0d: outputs=%h mask=%b, required %h %b",
                        cyc, outputs, out_lane_vld, snap_o, snap_m);
            end
         end
         if (out_vld === 1'b1 && out_rdy === 1'b1) begin
            eo = exp_o.pop_front();
            em = exp_m.pop_front();
            n_checks++;
            if (outputs !== eo || out_lane_vld !== em) begin
               n_fail++;
               $display("FAIL b2b_result %0d: outputs=%h mask=%b, required %h %b",
                        got, outputs, out_lane_vld, eo, em);
            end
            got++;
         end
         if (in_vld && in_rdy === 1'b1) sent++;
         cyc++;
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      n_checks++;
      if (got !== 16) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d beats, required 16", got);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_extra: out_vld=%b after last beat, required 0", out_vld);
         end
      end
   endtask

   task automatic test_random_stream();
      logic [127:0] beats [40];
      logic [1:0]   mds   [40];
      logic [63:0]  exp_o [$];
      logic [3:0]   exp_m [$];
      logic [63:0]  eo, snap_o;
      logic [3:0]   em, snap_m;
      logic [31:0]  r;
      bit           stall;
      int           sent, got, cyc;
      for (int i = 0; i < 40; i++) begin
         beats[i] = rand_beat();
         r        = $urandom;
         mds[i]   = r[1:0];
         ref_tree(beats[i], int'(r[1:0]), eo, em);
         exp_o.push_back(eo);
         exp_m.push_back(em);
      end
      sent = 0; got = 0; cyc = 0; stall = 1'b0; snap_o = '0; snap_m = '0;
      while (got < 40 && cyc < 800) begin
         @(negedge clk);
         r       = $urandom;
         out_rdy = (r[1:0] != 2'b00);
         in_vld  = (sent < 40) && (r[5:4] != 2'b00);
         if (sent < 40) begin
            mul_ins = beats[sent];
            mode    = mds[sent];
         end
         #1;
         if (stall) begin
            n_checks++;
            if (out_vld !== 1'b1 || outputs !== snap_o || out_lane_vld !== snap_m) begin
               n_fail++;
               $display("FAIL rand_stall cyc %0d: out_vld=%b outputs=%h mask=%b, required 1 %h %b",
                        cyc, out_vld, outputs, out_lane_vld, snap_o, snap_m);
            end
         end
         if (out_vld === 1'b1 && out_rdy === 1'b1) begin
            eo = exp_o.pop_front();
            em = exp_m.pop_front();
            n_checks++;
            if (outputs !== eo || out_lane_vld !== em) begin
               n_fail++;
               $display("FAIL rand_result %0d: outputs=%h mask=%b, required %h %b",
                        got, outputs, out_lane_vld, eo, em);
            end
            got++;
         end
         stall  = (out_vld === 1'b1) && !out_rdy;
         snap_o = outputs;
         snap_m = out_lane_vld;
         if (in_vld && in_rdy === 1'b1) sent++;
         cyc++;
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      n_checks++;
      if (got !== 40) begin
         n_fail++;
         $display("FAIL rand_count: got %0d beats, required 40", got);
      end
   endtask

   task automatic test_reset_midflight();
      logic [127:0] d;
      logic [63:0]  o, eo;
      logic [3:0]   m, em;
      int           lat, cyc;
      @(negedge clk);
      out_rdy = 1'b0;
      in_vld  = 1'b1;
      mul_ins = {8{16'h4000}};
      mode    = 2'd1;
      @(negedge clk);
      mul_ins = {8{16'h3F80}};
      mode    = 2'd2;
      @(negedge clk);
      in_vld = 1'b0;
      cyc = 0;
      while (out_vld !== 1'b1 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (out_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_setup: out_vld=%b before reset, required 1", out_vld);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (out_vld !== 1'b0 || outputs !== 64'h0 || out_lane_vld !== 4'h0) begin
         n_fail++;
         $display("FAIL rst_async: out_vld=%b outputs=%h mask=%b, required 0/0/0",
                  out_vld, outputs, out_lane_vld);
      end
      @(negedge clk);
      rst     = 1'b1;
      out_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stale: out_vld=%b %0d cycles after release, required 0",
                     out_vld, i + 1);
         end
      end
      d = rand_beat();
      ref_tree(d, 3, eo, em);
      run_beat(d, 2'd3, o, m, lat);
      n_checks++;
      if (o !== eo || m !== em || lat !== 3) begin
         n_fail++;
         $display("FAIL rst_recover: outputs=%h mask=%b lat=%0d, required %h %b 3",
                  o, m, lat, eo, em);
      end
   endtask

   initial begin
      test_reset();
      test_pairwise();
      test_modes();
      test_special();
      test_back_to_back();
      test_random_stream();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_tree_bf16_param.md
Name: mul_tree_bf16_param

Overview:
- Parametrised, pipelined bf16 multiplier tree and successor to the fixed 8-input, 4-output tree.
- Accepts N_IN bf16 operands per beat. Runtime mode selects how many product levels are applied: pairwise products, products of groups of 4, and so on up to the full product of all N_IN operands.
- Adds a valid/ready handshake with backpressure and a per-lane valid mask.
- Sits between the operand stimulus/feature buffer and the downstream accumulator.

Parameters:
- N_IN, 8, number of bf16 input operands; power of two, at least 2.
- LEVELS, log2(N_IN), tree depth; derived, not overridden.
- MW, clog2(LEVELS+1), width of the mode port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_vld  in  1  input beat valid.
- in_rdy  out  1  block can accept a beat.
- mul_ins  in  N_IN*16  operands; lane i occupies bits [16i+15:16i].
- mode  in  MW  number of product levels, 1..LEVELS; 0 is treated as 1; values above LEVELS are treated as LEVELS.
- out_vld  out  1  output beat valid.
- out_rdy  in  1  downstream accepts the beat.
- outputs  out  (N_IN/2)*16  result lanes; lane j occupies bits [16j+15:16j].
- out_lane_vld  out  N_IN/2  bit j is set when result lane j is meaningful.

Behaviour:
- Reset (rst low, asynchronous): all stage valids clear. out_vld, outputs and out_lane_vld read 0. in_rdy reads 1 once reset is released.
- Pipeline: LEVELS register stages, one stage per tree level, each stage N_IN/2 lanes wide. Level 0 is mul_ins.
- Each stage carries the beat's mode, so a mode change between beats is legal; no flush is needed.
- Stage k (1..LEVELS), when k <= mode:
  - lane j with j < N_IN/2^k = bf16mul(prev[2j], prev[2j+1]);
  - all higher lanes = 0.
- Stage k, when k > mode: each lane copies the previous stage unchanged.
- Fixed latency: an input accepted at edge t appears with out_vld=1 after edge t+LEVELS, independent of mode (no stalls).
- out_lane_vld = lanes 0..N_IN/2^mode - 1 set. Example for N_IN=8: mode 1 gives 1111, mode 2 gives 0011, mode 3 gives 0001.
- Handshake:
  - en = !out_vld | out_rdy; in_rdy = en.
  - An input is accepted on an edge with in_vld & in_rdy.
  - When en=1 all stages advance and a bubble enters if no input is accepted.
  - When en=0 every stage holds, and outputs, out_lane_vld and out_vld stay stable.
- No beat is lost or duplicated.
- Asserting in_vld while in_rdy=0 has no effect; the source must hold its data.
- bf16mul rules, checked in this order:
  - Either operand NaN (exp=255, mant!=0) -> 0x7FC0.
  - Inf times zero/subnormal -> 0x7FC0.
  - Otherwise inf operand -> signed inf (sign = xor of the two signs, exp=255, mant=0).
  - Zero or subnormal operand (exp=0) -> signed zero.
  - Normal case:
    - 8x8 significand product with hidden 1s, giving 16 bits;
    - normalise by 1 if bit 15 is set;
    - e = ea + eb - 127 (+1 if normalised);
    - round to nearest, ties to even, on the discarded bits;
    - if rounding carries out, renormalise and e += 1.
  - e >= 255 after rounding -> signed inf. e <= 0 -> signed zero; no subnormal outputs.
- Reset mid-operation: all in-flight beats are discarded and no output is produced for them.

Test Plan:
- N_IN=8, mode 1, pairs (0x4000,0x4040), (0x3FC0,0x4000), (0x3F80,0x3F80), (0xC000,0x3F00), in_vld pulse, out_rdy=1 -> 3 cycles later outputs lanes 0x40C0, 0x4040, 0x3F80, 0xBF80 (lane0 first); out_lane_vld=1111.
- Mode 3, all eight 0x4000 -> lane0=0x4380; lanes 1..3 = 0; out_lane_vld=0001. Mode 2, same inputs -> lanes 0x4180, 0x4180, 0, 0; mask 0011.
- Special values:
  - 0x7F80*0x0000 -> 0x7FC0;
  - 0x7F00*0x7F00 -> 0x7F80;
  - 0x0080*0x0080 -> 0x0000;
  - 0x8080*0x0080 -> 0x8000;
  - 0x7FC1*0x3F80 -> 0x7FC0.
- Rounding:
  - 0x3F81*0x3F81 -> 0x3F82;
  - tie 0x3F81*0x3FC0 -> 0x3FC2 (rounds up to even);
  - tie 0x3F83*0x3FC0 -> 0x3FC4 (rounds down to even);
  - carry case 0x3FC1*0x3FC1 -> 0x4012.
- Backpressure: stream 16 beats with in_vld=1 and alternating modes. Hold out_rdy=0 for 5 cycles mid-stream -> in_rdy=0 and outputs frozen during the hold. All 16 results arrive in order, each matching the reference model for its own mode.
- Reset: drive rst low with 2 beats in flight -> out_vld=0, outputs=0, out_lane_vld=0 immediately. After release, a new beat produces a correct result at latency 3 and nothing stale appears.
